// File: rtl/xkeypad_pkg.sv
// Shared key codes, widths and state/payload types for the xkeypad block.
package xkeypad_pkg;

  localparam int unsigned KEY_W      = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned DATA_W     = 11;
  localparam int unsigned MAG_W      = 10;
  localparam int unsigned MAX_DIGITS = 3;

  // Key code is col_index*4 + row_index.
  localparam logic [KEY_W-1:0] KEY_1    = 4'd0;
  localparam logic [KEY_W-1:0] KEY_4    = 4'd1;
  localparam logic [KEY_W-1:0] KEY_7    = 4'd2;
  localparam logic [KEY_W-1:0] KEY_STAR = 4'd3;
  localparam logic [KEY_W-1:0] KEY_2    = 4'd4;
  localparam logic [KEY_W-1:0] KEY_5    = 4'd5;
  localparam logic [KEY_W-1:0] KEY_8    = 4'd6;
  localparam logic [KEY_W-1:0] KEY_0    = 4'd7;
  localparam logic [KEY_W-1:0] KEY_3    = 4'd8;
  localparam logic [KEY_W-1:0] KEY_6    = 4'd9;
  localparam logic [KEY_W-1:0] KEY_9    = 4'd10;
  localparam logic [KEY_W-1:0] KEY_HASH = 4'd11;
  localparam logic [KEY_W-1:0] KEY_A    = 4'd12;
  localparam logic [KEY_W-1:0] KEY_B    = 4'd13;
  localparam logic [KEY_W-1:0] KEY_C    = 4'd14;
  localparam logic [KEY_W-1:0] KEY_D    = 4'd15;

  typedef enum logic [1:0] {SCAN_NONE, SCAN_SINGLE, SCAN_MULTI} scan_kind_e;
  typedef enum logic {RELEASED, PRESSED} db_state_e;
  typedef enum logic {ENTRY, CONVERT} entry_state_e;

  typedef struct packed {
    scan_kind_e       kind;
    logic [KEY_W-1:0] code;
  } scan_res_t;

  // Digit value of a key code; non-digit codes map to 0.
  function automatic logic [DIGIT_W-1:0] key_digit(input logic [KEY_W-1:0] code);
    case (code)
      KEY_1:   key_digit = 4'd1;
      KEY_2:   key_digit = 4'd2;
      KEY_3:   key_digit = 4'd3;
      KEY_4:   key_digit = 4'd4;
      KEY_5:   key_digit = 4'd5;
      KEY_6:   key_digit = 4'd6;
      KEY_7:   key_digit = 4'd7;
      KEY_8:   key_digit = 4'd8;
      KEY_9:   key_digit = 4'd9;
      KEY_0:   key_digit = 4'd0;
      default: key_digit = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/xkeypad_if.sv
// Keypad pins and processor read handshake of xkeypad; echo signals exist only with XKEYPAD_ECHO_EN.
interface xkeypad_if;
  import xkeypad_pkg::*;

  logic              sel;
  logic [3:0]        row;
  logic [3:0]        col;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ovr;
`ifdef XKEYPAD_ECHO_EN
  logic [MAX_DIGITS*DIGIT_W-1:0] echo_bcd;
  logic                          echo_neg;

  modport master (output sel, row, input col, data_out, valid, ovr, echo_bcd, echo_neg);
  modport slave  (input sel, row, output col, data_out, valid, ovr, echo_bcd, echo_neg);
`else
  modport master (output sel, row, input col, data_out, valid, ovr);
  modport slave  (input sel, row, output col, data_out, valid, ovr);
`endif
endinterface

// File: rtl/xkeypad_scan.sv
// Column scanner with row synchroniser and press/release debounce; emits a one-cycle key event.
module xkeypad_scan
  import xkeypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       row_i,
  output logic [3:0]       col_o,
  output logic [KEY_W-1:0] key_code_o,
  output logic             key_evt_o
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]       row_meta_q, row_sync_q;
  logic [DIV_W-1:0] div_q;
  logic [3:0]       col_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       hits_q;
  logic [KEY_W-1:0] code_q;
  logic             scan_stb_q;
  scan_res_t        scan_q;

  logic             slot_end;
  logic [2:0]       col_hits;
  logic [1:0]       col_row;
  logic [2:0]       hit_sum;
  logic [1:0]       tot_hits;
  logic [KEY_W-1:0] acc_code;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, run;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             evt_q, evt_d;

  assign slot_end = (div_q == DIV_W'(SCAN_DIV - 1));

  // Hits in the current column, folded into the running scan (saturating at 2 = multi).
  always_comb begin
    col_hits = 3'd0;
    col_row  = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) begin
        col_hits = col_hits + 3'd1;
        col_row  = 2'(r);
      end
    end
    hit_sum  = 3'(hits_q) + col_hits;
    tot_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    acc_code = (col_hits == 3'd1) ? {col_idx_q, col_row} : code_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
      div_q      <= '0;
      col_q      <= 4'b1110;
      col_idx_q  <= 2'd0;
      hits_q     <= 2'd0;
      code_q     <= '0;
      scan_stb_q <= 1'b0;
      scan_q     <= '{kind: SCAN_NONE, code: '0};
    end else begin
      row_meta_q <= row_i;
      row_sync_q <= row_meta_q;
      scan_stb_q <= 1'b0;
      if (slot_end) begin
        div_q     <= '0;
        col_q     <= {col_q[2:0], col_q[3]};
        col_idx_q <= col_idx_q + 2'd1;
        if (col_idx_q == 2'd3) begin
          scan_stb_q  <= 1'b1;
          scan_q.code <= acc_code;
          scan_q.kind <= (tot_hits == 2'd0) ? SCAN_NONE :
                         (tot_hits == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;
          hits_q      <= 2'd0;
          code_q      <= '0;
        end else begin
          hits_q <= tot_hits;
          code_q <= acc_code;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      evt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      evt_q   <= evt_d;
    end
  end

  // Debounce: count consecutive identical single-key scans to press, none scans to release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    evt_d   = 1'b0;
    run     = '0;
    if (scan_stb_q) begin
      case (state_q)
        RELEASED: begin
          if (scan_q.kind == SCAN_SINGLE) begin
            run = (cnt_q != '0 && scan_q.code == cand_q) ? cnt_q + CNT_W'(1) : CNT_W'(1);
            if (run >= CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = PRESSED;
              cnt_d   = '0;
              key_d   = scan_q.code;
              evt_d   = 1'b1;
            end else begin
              cnt_d  = run;
              cand_d = scan_q.code;
            end
          end else begin
            cnt_d = '0;
          end
        end
        PRESSED: begin
          if (scan_q.kind == SCAN_NONE) begin
            run = cnt_q + CNT_W'(1);
            if (run >= CNT_W'(DEBOUNCE_SCANS)) begin
              state_d = RELEASED;
              cnt_d   = '0;
            end else begin
              cnt_d = run;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = RELEASED;
      endcase
    end
  end

  assign col_o      = col_q;
  assign key_code_o = key_q;
  assign key_evt_o  = evt_q;

endmodule

// File: rtl/xkeypad.sv
// Keypad number entry: BCD entry, sequential BCD-to-binary conversion and read handshake.
// Optional XKEYPAD_ECHO_EN exposes the entry in progress on echo_bcd/echo_neg.
module xkeypad
  import xkeypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic   clk,
  input  logic   rst,
  xkeypad_if.slave bus
);

  logic [3:0]         col;
  logic [KEY_W-1:0]   key_code;
  logic               key_evt;

  entry_state_e       state_q, state_d;
  logic [DIGIT_W-1:0] hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
  logic [1:0]         ndig_q, ndig_d;
  logic               neg_q, neg_d;
  logic [1:0]         step_q, step_d;
  logic [MAG_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               ovr_q, ovr_d;
  logic               latch;
  logic [DATA_W-1:0]  mag;

  xkeypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scan (
    .clk        (clk),
    .rst        (rst),
    .row_i      (bus.row),
    .col_o      (col),
    .key_code_o (key_code),
    .key_evt_o  (key_evt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENTRY;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      ndig_q  <= 2'd0;
      neg_q   <= 1'b0;
      step_q  <= 2'd0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
      ndig_q  <= ndig_d;
      neg_q   <= neg_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign mag = DATA_W'(acc_q);

  // The # event already performs the first multiply-add step, so valid rises 4 clocks later.
  always_comb begin
    state_d = state_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    ndig_d  = ndig_q;
    neg_d   = neg_q;
    step_d  = step_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    latch   = 1'b0;
    case (state_q)
      ENTRY: begin
        if (key_evt) begin
          case (key_code)
            KEY_A: neg_d = ~neg_q;
            KEY_STAR: begin
              hund_d = '0;
              tens_d = '0;
              ones_d = '0;
              ndig_d = 2'd0;
              neg_d  = 1'b0;
            end
            KEY_HASH: begin
              state_d = CONVERT;
              acc_d   = MAG_W'(hund_q);
              step_d  = 2'd1;
            end
            KEY_B, KEY_C, KEY_D: ;
            default: begin
              if (ndig_q < 2'(MAX_DIGITS)) begin
                hund_d = tens_q;
                tens_d = ones_q;
                ones_d = key_digit(key_code);
                ndig_d = ndig_q + 2'd1;
              end
            end
          endcase
        end
      end
      CONVERT: begin
        case (step_q)
          2'd1: begin
            acc_d  = acc_q * MAG_W'(10) + MAG_W'(tens_q);
            step_d = 2'd2;
          end
          2'd2: begin
            acc_d  = acc_q * MAG_W'(10) + MAG_W'(ones_q);
            step_d = 2'd3;
          end
          default: begin
            latch   = 1'b1;
            data_d  = neg_q ? DATA_W'(0) - mag : mag;
            hund_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
            ndig_d  = 2'd0;
            neg_d   = 1'b0;
            acc_d   = '0;
            step_d  = 2'd0;
            state_d = ENTRY;
          end
        endcase
      end
      default: state_d = ENTRY;
    endcase

    // A read clears valid/ovr; a latch in the same cycle takes priority.
    if (bus.sel) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    if (latch) begin
      valid_d = 1'b1;
      ovr_d   = !bus.sel && (valid_q || ovr_q);
    end
  end

  assign bus.col      = col;
  assign bus.data_out = data_q;
  assign bus.valid    = valid_q;
  assign bus.ovr      = ovr_q;
`ifdef XKEYPAD_ECHO_EN
  assign bus.echo_bcd = {hund_q, tens_q, ones_q};
  assign bus.echo_neg = neg_q;
`endif

endmodule

// File: tb/tb_xkeypad.sv
// Directed bench for xkeypad with a behavioural 4x4 matrix keypad model.
module tb_xkeypad;

  // Key codes derived from the keypad layout: code = col*4 + row.
  localparam logic [3:0] K1 = 4'd0,  K4 = 4'd1,  K7 = 4'd2,  KST = 4'd3;
  localparam logic [3:0] K2 = 4'd4,  K5 = 4'd5,  K8 = 4'd6,  K0  = 4'd7;
  localparam logic [3:0] K3 = 4'd8,  K6 = 4'd9,  K9 = 4'd10, KH  = 4'd11;
  localparam logic [3:0] KA = 4'd12;
  localparam int HOLD = 80;
  localparam int GAP  = 80;

  logic        clk;
  logic        rst;
  logic [15:0] keys;
  logic [3:0]  row_v;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          seen;

  xkeypad_if ifc ();

  xkeypad #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_v = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!ifc.col[c] && keys[c*4+r]) row_v[r] = 1'b0;
  end
  assign ifc.row = row_v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [3:0] code);
    keys       = '0;
    keys[code] = 1'b1;
    repeat (HOLD) @(negedge clk);
    keys = '0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic sel_pulse();
    @(negedge clk);
    ifc.sel = 1'b1;
    @(negedge clk);
    ifc.sel = 1'b0;
  endtask

  // Hold # until the debounced key event appears; returns on the negedge it is seen.
  task automatic hash_wait_evt(output bit found);
    keys     = '0;
    keys[KH] = 1'b1;
    found    = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (dut.key_evt) found = 1'b1;
    end
  endtask

  task automatic release_keys();
    keys = '0;
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    ifc.sel = 1'b0;
    keys    = '0;
    repeat (3) @(negedge clk);
    check("rst_col",   32'(ifc.col), 32'h0E);
    check("rst_data",  32'(ifc.data_out), 0);
    check("rst_valid", 32'(ifc.valid), 0);
    check("rst_ovr",   32'(ifc.ovr), 0);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    press(K1); press(K2); press(K3); press(KH);
    check("e123_valid", 32'(ifc.valid), 1);
    check("e123_data",  32'(ifc.data_out), 32'h07B);
    check("e123_ovr",   32'(ifc.ovr), 0);
    sel_pulse();
    check("e123_sel_valid", 32'(ifc.valid), 0);
    check("e123_hold_data", 32'(ifc.data_out), 32'h07B);

    press(KA); press(K9); press(K9); press(K9); press(KH);
    check("neg999_data", 32'(ifc.data_out), 32'h419);
    sel_pulse();
    press(KA); press(KH);
    check("neg0_valid", 32'(ifc.valid), 1);
    check("neg0_data",  32'(ifc.data_out), 0);
    sel_pulse();

    press(K4); press(K5); press(K6); press(K7); press(KH);
    check("four_digit_data", 32'(ifc.data_out), 456);
    sel_pulse();
    press(K5); press(KST); press(K8); press(KH);
    check("star_data", 32'(ifc.data_out), 8);
    sel_pulse();

    press(K1); press(K2); press(KH);
    check("e12_data", 32'(ifc.data_out), 12);
    check("e12_ovr",  32'(ifc.ovr), 0);
    press(K3); press(K4); press(KH);
    check("e34_data",  32'(ifc.data_out), 34);
    check("e34_valid", 32'(ifc.valid), 1);
    check("e34_ovr",   32'(ifc.ovr), 1);
    sel_pulse();
    check("ovr_sel_valid", 32'(ifc.valid), 0);
    check("ovr_sel_ovr",   32'(ifc.ovr), 0);

    press(K7); press(K8); press(KH);
    check("e78_data", 32'(ifc.data_out), 78);
    press(K9); press(K0);
    hash_wait_evt(seen);
    check("coinc_evt", 32'(seen), 1);
    repeat (3) @(negedge clk);
    ifc.sel = 1'b1;
    @(negedge clk);
    ifc.sel = 1'b0;
    check("coinc_valid", 32'(ifc.valid), 1);
    check("coinc_ovr",   32'(ifc.ovr), 0);
    check("coinc_data",  32'(ifc.data_out), 90);
    @(negedge clk);
    check("coinc_hold_valid", 32'(ifc.valid), 1);
    release_keys();
    sel_pulse();

    keys     = '0;
    keys[K5] = 1'b1;
    repeat (10) @(negedge clk);
    keys = '0;
    repeat (GAP) @(negedge clk);
    keys     = '0;
    keys[K1] = 1'b1;
    keys[K2] = 1'b1;
    repeat (HOLD) @(negedge clk);
    keys = '0;
    repeat (GAP) @(negedge clk);
    keys     = '0;
    keys[K3] = 1'b1;
    repeat (320) @(negedge clk);
    keys = '0;
    repeat (GAP) @(negedge clk);
    press(KH);
    check("debounce_data",  32'(ifc.data_out), 3);
    check("debounce_valid", 32'(ifc.valid), 1);

    press(K9);
    hash_wait_evt(seen);
    check("rstconv_evt", 32'(seen), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstconv_col",   32'(ifc.col), 32'h0E);
    check("rstconv_data",  32'(ifc.data_out), 0);
    check("rstconv_valid", 32'(ifc.valid), 0);
    check("rstconv_ovr",   32'(ifc.ovr), 0);
    keys = '0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    press(K7);
    hash_wait_evt(seen);
    check("lat_evt", 32'(seen), 1);
    repeat (3) @(negedge clk);
    check("lat_early_valid", 32'(ifc.valid), 0);
    @(negedge clk);
    check("lat_valid", 32'(ifc.valid), 1);
    check("lat_data",  32'(ifc.data_out), 7);
    release_keys();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
